// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: BCD digits, packed lap entries and default lap depth.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    // d4 is the most significant digit, so the packed value reads {d4,d3,d2,d1}.
    typedef struct packed {
        bcd_t d4;
        bcd_t d3;
        bcd_t d2;
        bcd_t d1;
    } lap_t;

    localparam int unsigned LAP_DEPTH_DEFAULT = 8;

    function automatic lap_t lap_pack(bcd_t d4, bcd_t d3, bcd_t d2, bcd_t d1);
        lap_t l;
        l.d4 = d4;
        l.d3 = d3;
        l.d2 = d2;
        l.d1 = d1;
        return l;
    endfunction

endpackage

// File: rtl/lap_memory_if.sv
// Lap memory signal bundle: control pulses, live digits in, displayed lap and status out.
interface lap_memory_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEPTH = LAP_DEPTH_DEFAULT
);
    logic clear;
    logic lap;
    logic recall;
    bcd_t d1, d2, d3, d4;
    bcd_t q1, q2, q3, q4;
    logic [$clog2(DEPTH+1)-1:0] lap_count;
    logic [$clog2(DEPTH)-1:0]   view_age;
    logic full;

    modport master (
        output clear, lap, recall, d1, d2, d3, d4,
        input  q1, q2, q3, q4, lap_count, view_age, full
    );

    modport slave (
        input  clear, lap, recall, d1, d2, d3, d4,
        output q1, q2, q3, q4, lap_count, view_age, full
    );
endinterface

// File: rtl/lap_memory.sv
// Circular lap history: captures live stopwatch digits on lap, steps back through
// stored laps on recall, and presents the selected lap on registered BCD outputs.
module lap_memory
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEPTH = LAP_DEPTH_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    lap_memory_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    lap_t mem_q [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t view_age_q, view_age_d;
    ptr_t rd_idx;
    cnt_t count_q, count_d;
    lap_t q_q, q_d;
    lap_t din;
    logic full_q, full_d;
    logic do_lap;
    logic do_recall;

    // Next-state: clear beats lap, lap beats recall; recall on an empty history is a no-op.
    always_comb begin
        din        = lap_pack(bus.d4, bus.d3, bus.d2, bus.d1);
        do_lap     = bus.lap & ~bus.clear;
        do_recall  = bus.recall & ~bus.lap & ~bus.clear & (count_q != '0);
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        view_age_d = view_age_q;
        q_d        = q_q;
        rd_idx     = '0;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            count_d    = '0;
            view_age_d = '0;
            q_d        = '0;
        end else if (do_lap) begin
            wr_ptr_d   = wr_ptr_q + ptr_t'(1);
            count_d    = full_q ? count_q : count_q + cnt_t'(1);
            view_age_d = '0;
            // New entry is shown directly from the inputs; the array write lands same edge.
            q_d        = din;
        end else if (do_recall) begin
            view_age_d = (cnt_t'(view_age_q) == count_q - cnt_t'(1)) ? '0
                                                                     : view_age_q + ptr_t'(1);
            // Power-of-two depth makes pointer arithmetic wrap naturally.
            rd_idx     = wr_ptr_q - ptr_t'(1) - view_age_d;
            q_d        = mem_q[rd_idx];
        end
        full_d = (count_d == cnt_t'(DEPTH));
    end

    // Pointer, count, view and display registers; history is discarded on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            view_age_q <= '0;
            q_q        <= '0;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            view_age_q <= view_age_d;
            q_q        <= q_d;
            full_q     <= full_d;
        end
    end

    // Entry storage; not reset because only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_lap) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign bus.q1        = q_q.d1;
    assign bus.q2        = q_q.d2;
    assign bus.q3        = q_q.d3;
    assign bus.q4        = q_q.d4;
    assign bus.lap_count = count_q;
    assign bus.view_age  = view_age_q;
    assign bus.full      = full_q;

endmodule

// File: tb/tb_lap_memory.sv
// Directed bench for lap_memory: capture, recall walk, overwrite, priority, clear, async reset.
module tb_lap_memory;
    import stopwatch_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    lap_memory_if #(.DEPTH(8)) bus ();

    lap_memory #(.DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] q, input int cnt,
                             input int age, input logic f);
        chk({tag, "_q"}, {16'h0, bus.q4, bus.q3, bus.q2, bus.q1}, {16'h0, q});
        chk({tag, "_count"}, 32'(bus.lap_count), 32'(cnt));
        chk({tag, "_age"}, 32'(bus.view_age), 32'(age));
        chk({tag, "_full"}, 32'(bus.full), 32'(f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [15:0] v);
        bus.d1 = v[3:0];
        bus.d2 = v[7:4];
        bus.d3 = v[11:8];
        bus.d4 = v[15:12];
    endtask

    task automatic do_lap(input logic [15:0] v);
        set_digits(v);
        bus.lap = 1'b1;
        tick();
        bus.lap = 1'b0;
    endtask

    task automatic do_recall();
        bus.recall = 1'b1;
        tick();
        bus.recall = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bus.clear  = 1'b0;
        bus.lap    = 1'b0;
        bus.recall = 1'b0;
        set_digits(16'h0000);
        tick();
        tick();
        chk_state("reset", 16'h0000, 0, 0, 1'b0);
        reset = 1'b0;
        tick();
        chk_state("idle", 16'h0000, 0, 0, 1'b0);

        // Recall on empty history does nothing
        do_recall();
        chk_state("recall_empty", 16'h0000, 0, 0, 1'b0);

        // Single lap with d1..d4 = 1,2,3,4
        do_lap(16'h4321);
        chk_state("lap1", 16'h4321, 1, 0, 1'b0);

        // Three laps then recall walk
        do_clear();
        chk_state("clear1", 16'h0000, 0, 0, 1'b0);
        do_lap(16'h0001);
        do_lap(16'h0002);
        do_lap(16'h0003);
        chk_state("three_laps", 16'h0003, 3, 0, 1'b0);
        do_recall();
        chk_state("rc1", 16'h0002, 3, 1, 1'b0);
        do_recall();
        chk_state("rc2", 16'h0001, 3, 2, 1'b0);
        do_recall();
        chk_state("rc3_wrap", 16'h0003, 3, 0, 1'b0);

        // Lap and recall together at view_age 2: lap wins
        do_recall();
        do_recall();
        chk_state("pre_coinc", 16'h0001, 3, 2, 1'b0);
        set_digits(16'h0007);
        bus.lap    = 1'b1;
        bus.recall = 1'b1;
        tick();
        bus.lap    = 1'b0;
        bus.recall = 1'b0;
        chk_state("coinc", 16'h0007, 4, 0, 1'b0);
        do_recall();
        chk_state("coinc_rc", 16'h0003, 4, 1, 1'b0);

        // Nine laps into depth 8: oldest overwritten
        do_clear();
        chk_state("clear2", 16'h0000, 0, 0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            do_lap(16'(i));
            if (i == 7) chk_state("seven", 16'h0007, 7, 0, 1'b0);
            if (i == 8) chk_state("eight", 16'h0008, 8, 0, 1'b1);
        end
        chk_state("nine", 16'h0009, 8, 0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            do_recall();
            chk_state($sformatf("wrap_rc%0d", k), 16'(9 - k), 8, k, 1'b1);
        end
        do_recall();
        chk_state("wrap_rc8", 16'h0009, 8, 0, 1'b1);

        // Clear coincident with lap: nothing stored
        bus.clear = 1'b1;
        do_lap(16'h0055);
        bus.clear = 1'b0;
        chk_state("clear_lap", 16'h0000, 0, 0, 1'b0);
        do_recall();
        chk_state("clear_lap_rc", 16'h0000, 0, 0, 1'b0);

        // Non-BCD digits stored verbatim
        do_lap(16'hfabc);
        chk_state("nonbcd", 16'hfabc, 1, 0, 1'b0);
        do_recall();
        chk_state("single_rc", 16'hfabc, 1, 0, 1'b0);

        // Async reset between edges after five laps
        do_clear();
        for (int i = 1; i <= 5; i++) do_lap(16'(i));
        do_recall();
        chk_state("five_rc", 16'h0004, 5, 1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_rst", 16'h0000, 0, 0, 1'b0);
        #1;
        reset = 1'b0;
        do_lap(16'h0007);
        chk_state("post_rst", 16'h0007, 1, 0, 1'b0);
        do_lap(16'h0008);
        do_recall();
        chk_state("post_rst_rc", 16'h0007, 2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
